data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the processor's data bus. It samples MREQ/WRITE/SIZE/DAD from the core and services byte, half and word loads and stores against an internal word-organised RAM. It drives read data onto DDT and signals completion on ACKD_n after a programmable number of wait states. It sits in the system testbench/SoC opposite the core's data-memory port and is the reference slave for exercising the core's ACKD_n handling.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words (4 KiB default); power of two.
- WAIT_CYCLES, 1: wait states inserted before acknowledge; 0..15.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- MREQ  input  1  access request from core.
- WRITE  input  1  1 = store, 0 = load; qualified by MREQ.
- SIZE  input  2  00 word, 01 half, 10 byte, 11 reserved.
- DAD  input  32  byte address of access.
- DDT  inout  32  store data from core (right-aligned); load data to core during acknowledge, else high-Z.
- ACKD_n  output  1  active-low acknowledge, one cycle per request.
- ERR  output  1  high with ACKD_n low when the request was rejected.

## Operation
- States: IDLE, WAIT, ACK. Registered outputs; DDT driven only in ACK for loads.
- IDLE: on a rising edge with MREQ=1, latch DAD, SIZE, WRITE, and DDT (store data). Evaluate request validity. Go to ACK if WAIT_CYCLES=0, else go to WAIT with cnt=WAIT_CYCLES.
- WAIT: decrement cnt each edge. Go to ACK on the edge where cnt==1. MREQ is ignored while in WAIT.
- ACK: ACKD_n=0 for exactly one cycle, then return to IDLE unconditionally. A request still asserted in the following IDLE cycle is treated as a new request.
- Range check: DAD >= BASE_ADDR and DAD < BASE_ADDR + 4*DEPTH_WORDS. Word index = (DAD - BASE_ADDR) >> 2; lane = DAD[1:0].
- Alignment check: half requires DAD[0]=0; word requires DAD[1:0]=00. SIZE=11 is always invalid.
- Invalid request (out of range, misaligned, or SIZE=11): ERR=1 in the ACK cycle, no RAM update, load data = 0.
- Store, little-endian lane enables:
  - byte: lane DAD[1:0] <= DDT[7:0].
  - half: lanes {DAD[1],0} and {DAD[1],1} <= DDT[15:0].
  - word: all lanes <= DDT[31:0].
  - Unselected lanes unchanged.
- Load: the selected lanes are shifted to bit 0 and zero-extended (byte -> [7:0], half -> [15:0], word -> full). Sign extension is the core's job.
- RAM contents are not initialised or cleared by reset. The bench preloads them via hierarchical access or $readmemh on the array.

## Timing
- Reset values: state IDLE, cnt=0, ACKD_n=1, ERR=0, DDT high-Z, all latched request registers 0.
- Latency: request sampled at edge E0; ACKD_n low during the cycle after edge E0+WAIT_CYCLES. Total latency WAIT_CYCLES+1 cycles.
- Store commit: the RAM write happens on the edge entering ACK. A load issued next sees the new data.
- Load data: registered on the edge entering ACK and stable on DDT for the whole ACK cycle. DDT returns to high-Z on the edge leaving ACK.
- Throughput: at most one access per WAIT_CYCLES+2 cycles, because ACK->IDLE costs one cycle.
- Reset mid-operation (rst low in WAIT or ACK): outputs return to reset values immediately. A pending store whose ACK edge has not occurred is dropped; the RAM keeps its prior contents.
- MREQ=0 in IDLE: no state change, ACKD_n stays 1.
- DDT must never be driven by both ends at once: the responder drives only when WRITE was latched 0 and the state is ACK.

## Test plan
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF @0x100, then load @0x100. ACKD_n low 2 cycles after each request, DDT=0xDEADBEEF, ERR=0.
- Byte/half lanes: after the word above, store byte 0xAA @0x102, then load word. Expect 0xDEAABEEF; load half @0x102 -> 0x0000DEAA; load byte @0x101 -> 0x000000BE.
- Errors: load word @0x102 and store half @0x101 each give ERR=1 with ACKD_n=0 and no RAM change. Load @0x1000 (out of range, default depth) gives ERR=1 with DDT=0.
- WAIT_CYCLES=0 and 3: back-to-back requests with MREQ held. ACK latency 1 and 4 cycles respectively, one IDLE cycle between ACKs, no missed or duplicated ACK.
- Reset in WAIT: store 0x12345678 @0x10 (prior 0), pull rst low before ACK. ACKD_n=1 and DDT=Z immediately; a later load @0x10 returns 0x00000000.
- Bus hygiene: DDT is high-Z in every non-ACK cycle and during store ACKs (checked every cycle).

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory slave with wait states, lane-enabled stores and zero-extended loads
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        ERR
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        write_q, ack_n_q, err_q, drive_q;
  logic        ack_n_nxt, err_nxt, drive_nxt;
  logic [31:0] rdata_nxt;
  logic [31:0] mem [DEPTH_WORDS];

  // Zero-wait requests enter ACK straight from IDLE, so the live bus is used there
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_write;
  assign req_addr  = (state == S_IDLE) ? DAD   : addr_q;
  assign req_wdata = (state == S_IDLE) ? DDT   : wdata_q;
  assign req_size  = (state == S_IDLE) ? SIZE  : size_q;
  assign req_write = (state == S_IDLE) ? WRITE : write_q;

  logic [32:0]   offset;
  logic [AW-1:0] word_idx;
  logic          aligned, req_valid, enter_ack;
  assign offset    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign word_idx  = offset[AW+1:2];
  assign req_valid = (offset < SPAN) && aligned;
  assign enter_ack = (state_nxt == S_ACK);

  always_comb begin
    aligned = 1'b0;
    case (req_size)
      2'b00:   aligned = (req_addr[1:0] == 2'b00);
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  logic [31:0] word_rd, shifted, load_data, lane_data;
  logic [3:0]  lane_en;
  assign word_rd = mem[word_idx];
  assign shifted = word_rd >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_data = '0;
    lane_en   = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        load_data = word_rd;
        lane_en   = 4'b1111;
      end
      2'b01: begin
        load_data = {16'h0000, shifted[15:0]};
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        load_data = {24'h000000, shifted[7:0]};
        lane_en   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      default: begin
        load_data = '0;
        lane_en   = 4'b0000;
      end
    endcase
  end

  // Store commits on the edge entering ACK; a reset before that edge drops it
  always_ff @(posedge clk) begin
    if (rst && enter_ack && req_write && req_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      ack_n_q <= 1'b1;
      err_q   <= 1'b0;
      drive_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (state == S_IDLE && MREQ) begin
        addr_q  <= DAD;
        wdata_q <= DDT;
        size_q  <= SIZE;
        write_q <= WRITE;
      end
      ack_n_q <= ack_n_nxt;
      err_q   <= err_nxt;
      drive_q <= drive_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (MREQ) begin
          if (WAIT_INIT == 4'd0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_n_nxt = ~enter_ack;
    err_nxt   = enter_ack && !req_valid;
    drive_nxt = enter_ack && !req_write;
    rdata_nxt = (enter_ack && !req_write && req_valid) ? load_data : '0;
  end

  assign ACKD_n = ack_n_q;
  assign ERR    = err_q;
  assign DDT    = drive_q ? rdata_q : 'z;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b0;
  logic        mreq = 1'b0, mreq_b = 1'b0, write = 1'b0, tb_oe = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] dad = '0, tb_ddt = '0;
  wire  [31:0] ddt, ddt0, ddt3;
  logic        ack_n, err, ack_n0, err0, ack_n3, err3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  assign ddt = tb_oe ? tb_ddt : 'z;
  pullup pu_ddt  (ddt);
  pullup pu_ddt0 (ddt0);
  pullup pu_ddt3 (ddt3);

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .MREQ(mreq), .WRITE(write), .SIZE(size), .DAD(dad),
    .DDT(ddt), .ACKD_n(ack_n), .ERR(err));
  data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MREQ(mreq_b), .WRITE(write), .SIZE(size), .DAD(dad),
    .DDT(ddt0), .ACKD_n(ack_n0), .ERR(err0));
  data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .MREQ(mreq_b), .WRITE(write), .SIZE(size), .DAD(dad),
    .DDT(ddt3), .ACKD_n(ack_n3), .ERR(err3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one request to dut1 (WAIT_CYCLES=1) starting at a falling edge
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_d);
    exp_t e;
    int   lat;
    e.err  = exp_err;
    e.data = wr ? HIZ : exp_d;
    sb.push_back(e);
    mreq = 1'b1; write = wr; size = sz; dad = a; tb_ddt = wd; tb_oe = wr;
    @(posedge clk);
    @(negedge clk);
    mreq = 1'b0; tb_oe = 1'b0;
    lat = 1;
    while (ack_n === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", lat, 2);
    e = sb.pop_front();
    chk("ack_err", {31'b0, err}, {31'b0, e.err});
    chk("ack_ddt", ddt, e.data);
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, ack_n}, 32'd1);
  endtask

  // Bus hygiene: whenever neither side acknowledges nor the bench drives, DDT floats
  always @(negedge clk) begin
    #1;
    if (!tb_oe && ack_n === 1'b1) chk("ddt_idle_hiz", ddt, HIZ);
  end

  initial begin
    dut1.mem[4]    = 32'h0000_0000;
    dut1.mem[64]   = 32'h0000_0000;
    dut1.mem[1023] = 32'h7654_3210;
    dut0.mem[16]   = 32'h0BAD_F00D;
    dut3.mem[16]   = 32'h1357_9BDF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ackd_n", {31'b0, ack_n}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ddt", ddt, HIZ);
    rst = 1'b1;

    do_req(1'b1, 2'b00, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 32'h100, 32'h0,         1'b0, 32'hDEAD_BEEF);
    do_req(1'b1, 2'b10, 32'h102, 32'h1234_56AA, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 32'h100, 32'h0,         1'b0, 32'hDEAA_BEEF);
    do_req(1'b0, 2'b01, 32'h102, 32'h0,         1'b0, 32'h0000_DEAA);
    do_req(1'b0, 2'b10, 32'h101, 32'h0,         1'b0, 32'h0000_00BE);
    do_req(1'b0, 2'b00, 32'h102, 32'h0,         1'b1, 32'h0);
    do_req(1'b1, 2'b01, 32'h101, 32'h0000_5555, 1'b1, 32'h0);
    do_req(1'b0, 2'b00, 32'h100, 32'h0,         1'b0, 32'hDEAA_BEEF);
    do_req(1'b0, 2'b00, 32'h1000, 32'h0,        1'b1, 32'h0);
    do_req(1'b0, 2'b11, 32'h100, 32'h0,         1'b1, 32'h0);
    do_req(1'b1, 2'b01, 32'h102, 32'h9999_CAFE, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 32'h100, 32'h0,         1'b0, 32'hCAFE_BEEF);
    do_req(1'b0, 2'b00, 32'hFFC, 32'h0,         1'b0, 32'h7654_3210);

    // Reset while a store waits: it must be dropped
    mreq = 1'b1; write = 1'b1; size = 2'b00; dad = 32'h10; tb_ddt = 32'h1234_5678; tb_oe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mreq = 1'b0; tb_oe = 1'b0; rst = 1'b0;
    #1;
    chk("rst_wait_ackd_n", {31'b0, ack_n}, 32'd1);
    chk("rst_wait_ddt", ddt, HIZ);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 32'h0000_0000);

    // Reset during an error ACK that drives DDT=0
    mreq = 1'b1; write = 1'b0; size = 2'b00; dad = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    mreq = 1'b0;
    @(negedge clk);
    chk("pre_rst_ack", {31'b0, ack_n}, 32'd0);
    chk("pre_rst_err", {31'b0, err}, 32'd1);
    chk("pre_rst_ddt", ddt, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ack_ackd_n", {31'b0, ack_n}, 32'd1);
    chk("rst_ack_err", {31'b0, err}, 32'd0);
    chk("rst_ack_ddt", ddt, HIZ);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back loads with MREQ held on the zero- and three-wait instances
    write = 1'b0; size = 2'b00; dad = 32'h40;
    mreq_b = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      logic e0, e3;
      @(negedge clk);
      e0 = ((k - 1) % 2 == 0);
      e3 = (k >= 4) && ((k - 4) % 5 == 0);
      chk("b2b_w0_ack", {31'b0, ack_n0}, {31'b0, ~e0});
      chk("b2b_w3_ack", {31'b0, ack_n3}, {31'b0, ~e3});
      if (e0) chk("b2b_w0_data", ddt0, 32'h0BAD_F00D);
      if (e3) chk("b2b_w3_data", ddt3, 32'h1357_9BDF);
    end
    mreq_b = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
